// File: rtl/enemy_fire_scheduler.sv
// enemy_fire_scheduler
// A fire timer starts a round-robin scan over the enemy array. The first enemy
// that is alive and has a free bullet slot is issued to the bullet spawner over
// a valid/ready handshake, together with its saturated spawn coordinates.
// Optional feature: define FIRE_SCHED_RAND_EN to randomise the scan start and
// add jitter to the fire period. With this feature, FIRE_PERIOD must be > 256.
module enemy_fire_scheduler #(
    parameter int N_ENEMIES   = 5,
    parameter int COORD_W     = 10,
    parameter int FIRE_PERIOD = 25_000_000,
    parameter int X_OFFSET    = 10,
    parameter int Y_OFFSET    = 20
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pause,
    input  logic [N_ENEMIES-1:0]         enemy_alive,
    input  logic [N_ENEMIES*COORD_W-1:0] enemy_x,
    input  logic [N_ENEMIES*COORD_W-1:0] enemy_y,
    input  logic [N_ENEMIES-1:0]         bullet_busy,
    input  logic                         fire_ready,
    output logic                         fire_valid,
    output logic [2:0]                   fire_idx,
    output logic [COORD_W-1:0]           fire_x,
    output logic [COORD_W-1:0]           fire_y,
    output logic [7:0]                   shots_fired,
    output logic                         scan_active
);

    // FIRE_PERIOD-1 always fits in clog2(FIRE_PERIOD) bits for FIRE_PERIOD >= 2
    localparam int TIMER_W = $clog2(FIRE_PERIOD);
    localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(FIRE_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SCAN,
        ST_ISSUE
    } state_t;

    state_t               state;
    logic [TIMER_W-1:0]   timer;
    logic [2:0]           ptr;
    logic [2:0]           cand;
    logic [2:0]           checked;

    logic                 cand_ok;
    logic [COORD_W-1:0]   cand_x;
    logic [COORD_W-1:0]   cand_y;
    logic [COORD_W:0]     sum_x;
    logic [COORD_W:0]     sum_y;
    logic [COORD_W-1:0]   sat_x;
    logic [COORD_W-1:0]   sat_y;
    logic [2:0]           next_cand;
    logic [2:0]           next_ptr;
    logic [2:0]           scan_start;
    logic [TIMER_W-1:0]   reload_val;

`ifdef FIRE_SCHED_RAND_EN
    logic [7:0] lfsr;

    // Free-running Fibonacci LFSR, taps 8,6,5,4
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    // Randomised scan start and jittered timer reload
    always_comb begin
        scan_start = 3'(lfsr % 8'(N_ENEMIES));
        reload_val = RELOAD - TIMER_W'({lfsr[3:0], 4'b0000});
    end
`else
    // Strict round-robin start and fixed period
    always_comb begin
        scan_start = ptr;
        reload_val = RELOAD;
    end
`endif

    // Select the current candidate's status and coordinates, saturate the offsets
    always_comb begin
        cand_ok = 1'b0;
        cand_x  = '0;
        cand_y  = '0;
        for (int unsigned i = 0; i < N_ENEMIES; i++) begin
            if (cand == 3'(i)) begin
                cand_ok = enemy_alive[i] & ~bullet_busy[i];
                cand_x  = enemy_x[i*COORD_W +: COORD_W];
                cand_y  = enemy_y[i*COORD_W +: COORD_W];
            end
        end
        sum_x     = {1'b0, cand_x} + (COORD_W+1)'(X_OFFSET);
        sum_y     = {1'b0, cand_y} + (COORD_W+1)'(Y_OFFSET);
        sat_x     = sum_x[COORD_W] ? '1 : sum_x[COORD_W-1:0];
        sat_y     = sum_y[COORD_W] ? '1 : sum_y[COORD_W-1:0];
        next_cand = (cand == 3'(N_ENEMIES - 1)) ? '0 : cand + 3'd1;
        next_ptr  = (fire_idx == 3'(N_ENEMIES - 1)) ? '0 : fire_idx + 3'd1;
    end

    // Scheduler FSM: WAIT (timer) -> SCAN (one candidate per cycle) -> ISSUE (handshake)
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_WAIT;
            timer       <= RELOAD;
            ptr         <= '0;
            cand        <= '0;
            checked     <= '0;
            fire_valid  <= 1'b0;
            fire_idx    <= '0;
            fire_x      <= '0;
            fire_y      <= '0;
            shots_fired <= '0;
            scan_active <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (!pause) begin
                        if (timer == '0) begin
                            state       <= ST_SCAN;
                            cand        <= scan_start;
                            checked     <= '0;
                            scan_active <= 1'b1;
                        end else begin
                            timer <= timer - TIMER_W'(1);
                        end
                    end
                end
                ST_SCAN: begin
                    if (!pause) begin
                        if (cand_ok) begin
                            fire_idx    <= cand;
                            fire_x      <= sat_x;
                            fire_y      <= sat_y;
                            fire_valid  <= 1'b1;
                            scan_active <= 1'b0;
                            state       <= ST_ISSUE;
                        end else if (checked == 3'(N_ENEMIES - 1)) begin
                            timer       <= reload_val;
                            scan_active <= 1'b0;
                            state       <= ST_WAIT;
                        end else begin
                            cand    <= next_cand;
                            checked <= checked + 3'd1;
                        end
                    end
                end
                ST_ISSUE: begin
                    // The request is held regardless of pause or enemy state until accepted
                    if (fire_ready) begin
                        ptr        <= next_ptr;
                        fire_valid <= 1'b0;
                        timer      <= reload_val;
                        state      <= ST_WAIT;
                        if (shots_fired != 8'hFF) begin
                            shots_fired <= shots_fired + 8'd1;
                        end
                    end
                end
                default: begin
                    state       <= ST_WAIT;
                    fire_valid  <= 1'b0;
                    scan_active <= 1'b0;
                    timer       <= RELOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Directed testbench for enemy_fire_scheduler with FIRE_PERIOD=8.
// Fire cadence is 8 timer cycles + 1 scan + k skipped candidates + 1 issue.
module tb_enemy_fire_scheduler;

    localparam int N  = 5;
    localparam int W  = 10;
    localparam int FP = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             pause;
    logic [N-1:0]     alive;
    logic [N*W-1:0]   ex;
    logic [N*W-1:0]   ey;
    logic [N-1:0]     busy;
    logic             fire_ready;
    logic             fire_valid;
    logic [2:0]       fire_idx;
    logic [W-1:0]     fire_x;
    logic [W-1:0]     fire_y;
    logic [7:0]       shots_fired;
    logic             scan_active;

    int checks = 0;
    int errors = 0;

    enemy_fire_scheduler #(
        .N_ENEMIES  (N),
        .COORD_W    (W),
        .FIRE_PERIOD(FP),
        .X_OFFSET   (10),
        .Y_OFFSET   (20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pause      (pause),
        .enemy_alive(alive),
        .enemy_x    (ex),
        .enemy_y    (ey),
        .bullet_busy(busy),
        .fire_ready (fire_ready),
        .fire_valid (fire_valid),
        .fire_idx   (fire_idx),
        .fire_x     (fire_x),
        .fire_y     (fire_y),
        .shots_fired(shots_fired),
        .scan_active(scan_active)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the bench at a negedge with reset released; the state seen here is cycle 0
    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_defaults();
        pause      = 1'b0;
        alive      = '1;
        busy       = '0;
        fire_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            ex[i*W +: W] = W'(100 + i * 50);
            ey[i*W +: W] = W'(200 + i * 10);
        end
    endtask

    task automatic test_reset();
        set_defaults();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (fire_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", fire_valid); end
        checks++;
        if (fire_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", fire_idx); end
        checks++;
        if (fire_x !== 10'd0 || fire_y !== 10'd0) begin errors++; $display("FAIL reset_xy: got %0d/%0d expected 0/0", fire_x, fire_y); end
        checks++;
        if (shots_fired !== 8'd0) begin errors++; $display("FAIL reset_shots: got %0d expected 0", shots_fired); end
        checks++;
        if (scan_active !== 1'b0) begin errors++; $display("FAIL reset_scan: got %0b expected 0", scan_active); end
        reset = 1'b0;
    endtask

    task automatic test_round_robin();
        logic       exp_v;
        logic       exp_s;
        int         idx;
        set_defaults();
        apply_reset();
        for (int c = 1; c <= 60; c++) begin
            tick();
            exp_v = (c % 10 == 9);
            exp_s = (c % 10 == 8);
            checks++;
            if (fire_valid !== exp_v) begin errors++; $display("FAIL rr_valid c=%0d: got %0b expected %0b", c, fire_valid, exp_v); end
            checks++;
            if (scan_active !== exp_s) begin errors++; $display("FAIL rr_scan c=%0d: got %0b expected %0b", c, scan_active, exp_s); end
            if (exp_v) begin
                idx = (c / 10) % 5;
                checks++;
                if (fire_idx !== 3'(idx)) begin errors++; $display("FAIL rr_idx c=%0d: got %0d expected %0d", c, fire_idx, idx); end
                checks++;
                if (fire_x !== 10'(110 + idx * 50)) begin errors++; $display("FAIL rr_x c=%0d: got %0d expected %0d", c, fire_x, 110 + idx * 50); end
                checks++;
                if (fire_y !== 10'(220 + idx * 10)) begin errors++; $display("FAIL rr_y c=%0d: got %0d expected %0d", c, fire_y, 220 + idx * 10); end
            end
        end
        checks++;
        if (shots_fired !== 8'd6) begin errors++; $display("FAIL rr_shots: got %0d expected 6", shots_fired); end
    endtask

    task automatic test_sparse();
        logic exp_v;
        int   exp_i;
        set_defaults();
        alive = 5'b10100;
        apply_reset();
        for (int c = 1; c <= 35; c++) begin
            tick();
            exp_v = (c == 11 || c == 22 || c == 34);
            exp_i = (c == 22) ? 4 : 2;
            checks++;
            if (fire_valid !== exp_v) begin errors++; $display("FAIL sparse_valid c=%0d: got %0b expected %0b", c, fire_valid, exp_v); end
            if (exp_v) begin
                checks++;
                if (fire_idx !== 3'(exp_i)) begin errors++; $display("FAIL sparse_idx c=%0d: got %0d expected %0d", c, fire_idx, exp_i); end
            end
        end
    endtask

    task automatic test_all_dead();
        logic exp_s;
        set_defaults();
        alive = '0;
        apply_reset();
        for (int c = 1; c <= 100; c++) begin
            tick();
            exp_s = ((c % 13) >= 8);
            checks++;
            if (fire_valid !== 1'b0) begin errors++; $display("FAIL dead_valid c=%0d: got %0b expected 0", c, fire_valid); end
            checks++;
            if (scan_active !== exp_s) begin errors++; $display("FAIL dead_scan c=%0d: got %0b expected %0b", c, scan_active, exp_s); end
        end
        checks++;
        if (shots_fired !== 8'd0) begin errors++; $display("FAIL dead_shots: got %0d expected 0", shots_fired); end
    endtask

    task automatic test_stall();
        set_defaults();
        fire_ready = 1'b0;
        apply_reset();
        repeat (9) tick();
        checks++;
        if (fire_valid !== 1'b1) begin errors++; $display("FAIL stall_start: got %0b expected 1", fire_valid); end
        for (int c = 0; c < 20; c++) begin
            pause = ~pause;
            if (c == 3) alive = 5'b11110;
            if (c == 6) ex[0 +: W] = 10'd500;
            tick();
            checks++;
            if (fire_valid !== 1'b1 || fire_idx !== 3'd0 || fire_x !== 10'd110) begin
                errors++;
                $display("FAIL stall_hold c=%0d: got v=%0b idx=%0d x=%0d expected v=1 idx=0 x=110", c, fire_valid, fire_idx, fire_x);
            end
        end
        pause = 1'b0;
        fire_ready = 1'b1;
        tick();
        checks++;
        if (fire_valid !== 1'b0) begin errors++; $display("FAIL stall_release: got %0b expected 0", fire_valid); end
        checks++;
        if (shots_fired !== 8'd1) begin errors++; $display("FAIL stall_shots: got %0d expected 1", shots_fired); end
    endtask

    task automatic test_pause();
        logic exp_v;
        set_defaults();
        apply_reset();
        pause = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == 5) pause = 1'b0;
            exp_v = (c == 14);
            checks++;
            if (fire_valid !== exp_v) begin errors++; $display("FAIL pause_wait c=%0d: got %0b expected %0b", c, fire_valid, exp_v); end
        end
        // Pause in the middle of a scan: only enemy 4 eligible
        alive = 5'b10000;
        apply_reset();
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (c == 9) pause = 1'b1;
            if (c == 12) pause = 1'b0;
            exp_v = (c == 16);
            checks++;
            if (fire_valid !== exp_v) begin errors++; $display("FAIL pause_scan c=%0d: got %0b expected %0b", c, fire_valid, exp_v); end
            if (exp_v) begin
                checks++;
                if (fire_idx !== 3'd4) begin errors++; $display("FAIL pause_scan_idx: got %0d expected 4", fire_idx); end
            end
        end
    endtask

    task automatic test_saturate_and_reset();
        set_defaults();
        ex[0 +: W] = 10'd1020;
        ey[0 +: W] = 10'd1000;
        fire_ready = 1'b0;
        apply_reset();
        repeat (9) tick();
        checks++;
        if (fire_valid !== 1'b1) begin errors++; $display("FAIL sat_valid: got %0b expected 1", fire_valid); end
        checks++;
        if (fire_x !== 10'd1023) begin errors++; $display("FAIL sat_x: got %0d expected 1023", fire_x); end
        checks++;
        if (fire_y !== 10'd1020) begin errors++; $display("FAIL sat_y: got %0d expected 1020", fire_y); end
        // Reset mid-ISSUE drops the request
        reset = 1'b1;
        tick();
        checks++;
        if (fire_valid !== 1'b0 || fire_x !== 10'd0) begin errors++; $display("FAIL midreset: got v=%0b x=%0d expected v=0 x=0", fire_valid, fire_x); end
        reset = 1'b0;
        fire_ready = 1'b1;
        ex[0 +: W] = 10'd1013;
        for (int c = 1; c <= 10; c++) begin
            tick();
            checks++;
            if (fire_valid !== (c == 9)) begin errors++; $display("FAIL midreset_restart c=%0d: got %0b expected %0b", c, fire_valid, c == 9); end
        end
        // Handshake at the edge after cycle 9 completed at cycle 10; check the latched shot
        checks++;
        if (shots_fired !== 8'd1) begin errors++; $display("FAIL midreset_shots: got %0d expected 1", shots_fired); end
    endtask

    task automatic test_shot_saturation();
        set_defaults();
        apply_reset();
        for (int c = 1; c <= 3000; c++) begin
            tick();
            if (c == 9) begin
                checks++;
                if (fire_x !== 10'd110) begin errors++; $display("FAIL shots_first_x: got %0d expected 110", fire_x); end
            end
            if (c == 2549) begin
                checks++;
                if (shots_fired !== 8'd254) begin errors++; $display("FAIL shots_254: got %0d expected 254", shots_fired); end
            end
            if (c == 2550 || c == 3000) begin
                checks++;
                if (shots_fired !== 8'd255) begin errors++; $display("FAIL shots_255 c=%0d: got %0d expected 255", c, shots_fired); end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        set_defaults();
        test_reset();
        test_round_robin();
        test_sparse();
        test_all_dead();
        test_stall();
        test_pause();
        test_saturate_and_reset();
        test_shot_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
